data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Shares the single-port 32-word data memory between the MEM pipeline stage and the debug unit.
- On request, the debug unit receives a word-by-word dump of the whole memory for transmission over UART.
- The pipeline has priority. A starvation counter forces a one-cycle pipeline stall so the dump always progresses.
- Sits between the memory stage and data_memory, replacing the direct connection between them.

Parameters:
- ADDR_W, 5, memory word-address width.
- DATA_W, 32, data width.
- N_WORDS, 32, words dumped per request (addresses 0..N_WORDS-1).
- STARVE_LIMIT, 8, consecutive cycles the dump may be blocked before a stall is forced (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_pipe_read  in  1  MEM-stage read strobe.
- i_pipe_write  in  1  MEM-stage write strobe.
- i_pipe_addr  in  ADDR_W  MEM-stage word address.
- i_pipe_data  in  DATA_W  MEM-stage store data.
- o_pipe_data  out  DATA_W  load data returned to MEM stage.
- o_pipe_stall  out  1  freezes pipeline for one cycle; MEM access ignored that cycle.
- o_mem_read  out  1  to data_memory i_Read.
- o_mem_wenable  out  1  to data_memory i_wenable.
- o_mem_address  out  ADDR_W  to data_memory i_address.
- o_mem_data  out  DATA_W  to data_memory i_data.
- i_mem_data  in  DATA_W  from data_memory o_data; valid the cycle after a read.
- i_dbg_start  in  1  single-cycle dump request.
- i_dbg_ready  in  1  debug consumer accepts o_dbg_word.
- o_dbg_valid  out  1  o_dbg_word/o_dbg_addr valid.
- o_dbg_word  out  DATA_W  dumped word, registered.
- o_dbg_addr  out  ADDR_W  address of o_dbg_word.
- o_dbg_busy  out  1  dump in progress.
- o_dbg_done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- **Reset** (i_rst_n=0 at a clk edge):
  - FSM → IDLE; address counter and starve counter → 0.
  - All outputs 0; o_mem_* = 0.
  - Reset mid-dump aborts the dump without a done pulse.
- **Pipeline access:**
  - When i_pipe_read|i_pipe_write and o_pipe_stall=0, o_mem_* combinationally follow the pipe inputs. This adds zero latency.
  - o_pipe_data = i_mem_data, passed through.
  - If read and write are both high, the write wins and o_mem_read=0.
- **FSM states:**
  - IDLE:
    - i_dbg_start → REQ, addr=0, busy=1.
    - start while busy is ignored.
  - REQ:
    - If pipe idle or forced stall: drive o_mem_read=1, o_mem_address=addr → WAIT.
    - Otherwise the starve counter increments, and the FSM stays in REQ.
  - WAIT:
    - Latch i_mem_data into o_dbg_word and addr into o_dbg_addr.
    - o_dbg_valid=1 from the next cycle → PRESENT.
    - The memory is free to the pipeline in WAIT.
  - PRESENT:
    - Hold valid/word/addr stable until i_dbg_ready.
    - On valid&ready: valid←0.
    - If addr==N_WORDS-1 → DONE; else addr+1 → REQ.
  - DONE: o_dbg_done=1 for one cycle, busy←0 → IDLE.
- **Starvation:**
  - The starve counter resets to 0 on every debug grant and outside REQ.
  - When the counter reaches STARVE_LIMIT in REQ, o_pipe_stall=1 for exactly that cycle, the debug read is granted, and the counter clears.
  - o_pipe_stall is never asserted outside REQ.
- **Latency:**
  - Uncontended: start → first valid is 3 cycles (IDLE→REQ→WAIT→PRESENT).
  - Full dump with ready tied high: 3·N_WORDS+2 cycles.
- The pipeline never sees the debug read data. o_pipe_data in a stall cycle is don't-care.
- Writes to the current dump address after the debug read are not reflected in the dump. The dump is word-consistent, not snapshot-consistent.
- Address counter width is ADDR_W. It never wraps, because the terminal check precedes the increment.

Test Plan:
1. Reset held 2 cycles mid-PRESENT → o_dbg_valid=0, o_dbg_busy=0, o_pipe_stall=0, no o_dbg_done pulse; a new start then works.
2. Preload mem[k]=k·0x01010101, pipe idle, i_dbg_ready=1, pulse start → 32 valid beats, addr 0..31, data match; done pulse at cycle 98 after start.
3. i_dbg_ready held low 5 cycles at addr 3 → word/addr stable; i_pipe_write to addr 3 during hold → dump still shows the old value; next read of addr 3 by the pipe returns the new value.
4. Pipeline continuous reads with STARVE_LIMIT=8, start issued → exactly one o_pipe_stall pulse per dumped word, each 8 cycles after entering REQ; pipe reads in non-stall cycles return correct data.
5. Simultaneous i_pipe_read and i_pipe_write to addr 7, data 0xDEADBEEF → o_mem_wenable=1, o_mem_read=0; subsequent read returns 0xDEADBEEF.
6. Second i_dbg_start during a busy dump → ignored; exactly one done pulse, 32 beats total.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the single-port data memory between the MEM stage
// and the debug dump engine. The pipeline has priority. A starvation counter
// forces a one-cycle pipeline stall so that the dump always makes progress.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no dump in progress, waiting for i_dbg_start
// REQ     | waiting for a free memory slot to read the current address
// WAIT    | debug read issued, memory data arrives this cycle
// PRESENT | word held on o_dbg_* until the consumer accepts it
// DONE    | last word accepted, emit done pulse and return to IDLE

module data_mem_arbiter #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int N_WORDS      = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_pipe_read,
  input  logic              i_pipe_write,
  input  logic [ADDR_W-1:0] i_pipe_addr,
  input  logic [DATA_W-1:0] i_pipe_data,
  output logic [DATA_W-1:0] o_pipe_data,
  output logic              o_pipe_stall,
  output logic              o_mem_read,
  output logic              o_mem_wenable,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic [DATA_W-1:0] o_mem_data,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic              i_dbg_start,
  input  logic              i_dbg_ready,
  output logic              o_dbg_valid,
  output logic [DATA_W-1:0] o_dbg_word,
  output logic [ADDR_W-1:0] o_dbg_addr,
  output logic              o_dbg_busy,
  output logic              o_dbg_done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ     = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_PRESENT = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam int                CNT_W     = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  LIMIT     = CNT_W'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_starve;
  logic              r_valid;
  logic [DATA_W-1:0] r_word;
  logic [ADDR_W-1:0] r_dbg_addr;
  logic              r_busy;
  logic              r_done;

  logic w_pipe_req;
  logic w_in_req;
  logic w_stall;
  logic w_grant;

  assign w_pipe_req = i_pipe_read | i_pipe_write;
  assign w_in_req   = (r_state == S_REQ);
  // Once the dump has been blocked STARVE_LIMIT cycles, steal this one slot.
  assign w_stall    = w_in_req && (r_starve == LIMIT);
  assign w_grant    = w_in_req && (!w_pipe_req || w_stall);

  assign o_pipe_stall = i_rst_n & w_stall;
  // Load data passes straight through; during reset everything reads as 0.
  assign o_pipe_data  = i_rst_n ? i_mem_data : '0;
  assign o_dbg_valid  = r_valid;
  assign o_dbg_word   = r_word;
  assign o_dbg_addr   = r_dbg_addr;
  assign o_dbg_busy   = r_busy;
  assign o_dbg_done   = r_done;

  // Memory port mux: debug read when granted, otherwise the pipeline passes through.
  always_comb begin
    o_mem_read    = 1'b0;
    o_mem_wenable = 1'b0;
    o_mem_address = '0;
    o_mem_data    = '0;
    if (i_rst_n) begin
      if (w_grant) begin
        o_mem_read    = 1'b1;
        o_mem_address = r_addr;
      end else if (w_pipe_req) begin
        // A simultaneous read and write is treated as a write.
        o_mem_wenable = i_pipe_write;
        o_mem_read    = i_pipe_read & ~i_pipe_write;
        o_mem_address = i_pipe_addr;
        o_mem_data    = i_pipe_data;
      end
    end
  end

  // Starvation counter: counts blocked REQ cycles, cleared on grant or outside REQ.
  always_ff @(posedge clk) begin
    if (!i_rst_n || !w_in_req || w_grant) begin
      r_starve <= '0;
    end else begin
      r_starve <= r_starve + CNT_W'(1);
    end
  end

  // Dump sequencer FSM and its registered debug outputs.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_valid    <= 1'b0;
      r_word     <= '0;
      r_dbg_addr <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_dbg_start) begin
            r_state <= S_REQ;
            r_addr  <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_REQ: begin
          if (w_grant) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_word     <= i_mem_data;
          r_dbg_addr <= r_addr;
          r_valid    <= 1'b1;
          r_state    <= S_PRESENT;
        end
        S_PRESENT: begin
          if (r_valid && i_dbg_ready) begin
            r_valid <= 1'b0;
            // Terminal check comes first, so the address never wraps.
            if (r_addr == LAST_ADDR) begin
              r_state <= S_DONE;
            end else begin
              r_addr  <= r_addr + ADDR_W'(1);
              r_state <= S_REQ;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed bench for the memory arbiter / dump engine,
// with a behavioural single-port data memory (registered read data).

module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_pipe_read;
  logic        i_pipe_write;
  logic [4:0]  i_pipe_addr;
  logic [31:0] i_pipe_data;
  logic [31:0] o_pipe_data;
  logic        o_pipe_stall;
  logic        o_mem_read;
  logic        o_mem_wenable;
  logic [4:0]  o_mem_address;
  logic [31:0] o_mem_data;
  logic [31:0] i_mem_data = '0;
  logic        i_dbg_start;
  logic        i_dbg_ready;
  logic        o_dbg_valid;
  logic [31:0] o_dbg_word;
  logic [4:0]  o_dbg_addr;
  logic        o_dbg_busy;
  logic        o_dbg_done;

  logic [31:0] mem [0:31];
  logic        preload;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk           (clk),
    .i_rst_n       (i_rst_n),
    .i_pipe_read   (i_pipe_read),
    .i_pipe_write  (i_pipe_write),
    .i_pipe_addr   (i_pipe_addr),
    .i_pipe_data   (i_pipe_data),
    .o_pipe_data   (o_pipe_data),
    .o_pipe_stall  (o_pipe_stall),
    .o_mem_read    (o_mem_read),
    .o_mem_wenable (o_mem_wenable),
    .o_mem_address (o_mem_address),
    .o_mem_data    (o_mem_data),
    .i_mem_data    (i_mem_data),
    .i_dbg_start   (i_dbg_start),
    .i_dbg_ready   (i_dbg_ready),
    .o_dbg_valid   (o_dbg_valid),
    .o_dbg_word    (o_dbg_word),
    .o_dbg_addr    (o_dbg_addr),
    .o_dbg_busy    (o_dbg_busy),
    .o_dbg_done    (o_dbg_done)
  );

  // Data memory: synchronous write, read data valid the cycle after the read.
  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < 32; k++) mem[k] <= 32'(k) * 32'h01010101;
    end else if (o_mem_wenable) begin
      mem[o_mem_address] <= o_mem_data;
    end
    if (o_mem_read) i_mem_data <= mem[o_mem_address];
  end

  function automatic logic [31:0] wval(input int k);
    return 32'(k) * 32'h01010101;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; inputs change and outputs are sampled there.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    #1;
    while (!o_dbg_done && n < 400) begin
      cyc();
      #1;
      n++;
    end
    chk(tag, 32'(o_dbg_done), 32'd1);
    cyc();
  endtask

  initial begin
    int ev;
    int beats;
    int dones;
    int donecyc;
    int nstall;
    int prev_chk;
    logic [4:0] prev_addr;
    logic exp_stall;

    i_rst_n      = 1'b0;
    i_pipe_read  = 1'b1;
    i_pipe_write = 1'b0;
    i_pipe_addr  = 5'd5;
    i_pipe_data  = '0;
    i_dbg_start  = 1'b0;
    i_dbg_ready  = 1'b0;
    preload      = 1'b1;

    // Reset state
    @(negedge clk);
    cyc();
    preload = 1'b0;
    #1;
    chk("rst_mem_read", 32'(o_mem_read), 32'd0);
    chk("rst_mem_wen", 32'(o_mem_wenable), 32'd0);
    chk("rst_mem_addr", 32'(o_mem_address), 32'd0);
    chk("rst_stall", 32'(o_pipe_stall), 32'd0);
    chk("rst_valid", 32'(o_dbg_valid), 32'd0);
    chk("rst_busy", 32'(o_dbg_busy), 32'd0);
    chk("rst_done", 32'(o_dbg_done), 32'd0);
    chk("rst_word", o_dbg_word, 32'd0);
    chk("rst_dbg_addr", 32'(o_dbg_addr), 32'd0);
    cyc();
    i_rst_n     = 1'b1;
    i_pipe_read = 1'b0;
    cyc();

    // Full uncontended dump, ready tied high
    i_dbg_ready = 1'b1;
    i_dbg_start = 1'b1;
    cyc();
    i_dbg_start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      #1;
      ev = ((c % 3 == 0) && (c <= 96)) ? 1 : 0;
      chk("t2_valid", 32'(o_dbg_valid), 32'(ev));
      if (ev != 0) begin
        chk("t2_addr", 32'(o_dbg_addr), 32'(c / 3 - 1));
        chk("t2_word", o_dbg_word, wval(c / 3 - 1));
      end
      chk("t2_done", 32'(o_dbg_done), (c == 98) ? 32'd1 : 32'd0);
      chk("t2_busy", 32'(o_dbg_busy), (c >= 1 && c <= 97) ? 32'd1 : 32'd0);
      cyc();
    end

    // Simultaneous read and write: write wins
    i_pipe_read  = 1'b1;
    i_pipe_write = 1'b1;
    i_pipe_addr  = 5'd7;
    i_pipe_data  = 32'hDEADBEEF;
    #1;
    chk("t5_wen", 32'(o_mem_wenable), 32'd1);
    chk("t5_read", 32'(o_mem_read), 32'd0);
    chk("t5_addr", 32'(o_mem_address), 32'd7);
    chk("t5_wdata", o_mem_data, 32'hDEADBEEF);
    cyc();
    i_pipe_write = 1'b0;
    #1;
    chk("t5_read2", 32'(o_mem_read), 32'd1);
    cyc();
    i_pipe_read = 1'b0;
    #1;
    chk("t5_rdata", o_pipe_data, 32'hDEADBEEF);
    i_pipe_write = 1'b1;
    i_pipe_data  = wval(7);
    cyc();
    i_pipe_write = 1'b0;
    cyc();

    // Backpressure at addr 3 with a pipeline write during the hold
    i_dbg_start = 1'b1;
    cyc();
    i_dbg_start = 1'b0;
    for (int c = 1; c < 12; c++) cyc();
    i_dbg_ready = 1'b0;
    for (int h = 0; h < 5; h++) begin
      i_pipe_write = (h == 1);
      i_pipe_addr  = 5'd3;
      i_pipe_data  = 32'h12345678;
      #1;
      chk("t3_valid", 32'(o_dbg_valid), 32'd1);
      chk("t3_addr", 32'(o_dbg_addr), 32'd3);
      chk("t3_word", o_dbg_word, wval(3));
      if (h == 1) chk("t3_wen", 32'(o_mem_wenable), 32'd1);
      cyc();
    end
    i_pipe_write = 1'b0;
    i_dbg_ready  = 1'b1;
    #1;
    chk("t3_word_after", o_dbg_word, wval(3));
    wait_done("t3_done");
    i_pipe_read = 1'b1;
    i_pipe_addr = 5'd3;
    cyc();
    i_pipe_read = 1'b0;
    #1;
    chk("t3_newval", o_pipe_data, 32'h12345678);
    i_pipe_write = 1'b1;
    i_pipe_data  = wval(3);
    cyc();
    i_pipe_write = 1'b0;
    cyc();

    // Reset held two cycles mid-PRESENT
    i_dbg_ready = 1'b0;
    i_dbg_start = 1'b1;
    cyc();
    i_dbg_start = 1'b0;
    cyc();
    cyc();
    #1;
    chk("t1_valid_pre", 32'(o_dbg_valid), 32'd1);
    i_rst_n = 1'b0;
    for (int r = 0; r < 2; r++) begin
      cyc();
      #1;
      chk("t1_valid_rst", 32'(o_dbg_valid), 32'd0);
      chk("t1_busy_rst", 32'(o_dbg_busy), 32'd0);
      chk("t1_stall_rst", 32'(o_pipe_stall), 32'd0);
      chk("t1_done_rst", 32'(o_dbg_done), 32'd0);
    end
    i_rst_n = 1'b1;
    for (int r = 0; r < 5; r++) begin
      cyc();
      #1;
      chk("t1_done_after", 32'(o_dbg_done), 32'd0);
      chk("t1_busy_after", 32'(o_dbg_busy), 32'd0);
    end
    cyc();
    i_dbg_ready = 1'b1;
    i_dbg_start = 1'b1;
    cyc();
    i_dbg_start = 1'b0;
    cyc();
    cyc();
    #1;
    chk("t1_restart_valid", 32'(o_dbg_valid), 32'd1);
    chk("t1_restart_addr", 32'(o_dbg_addr), 32'd0);
    chk("t1_restart_busy", 32'(o_dbg_busy), 32'd1);
    wait_done("t1_done");

    // Second start during a busy dump is ignored
    i_dbg_start = 1'b1;
    cyc();
    beats   = 0;
    dones   = 0;
    donecyc = 0;
    for (int c = 1; c <= 110; c++) begin
      i_dbg_start = (c == 10);
      #1;
      if (o_dbg_valid && i_dbg_ready) beats++;
      if (o_dbg_done) begin
        dones++;
        donecyc = c;
      end
      cyc();
    end
    i_dbg_start = 1'b0;
    chk("t6_beats", 32'(beats), 32'd32);
    chk("t6_dones", 32'(dones), 32'd1);
    chk("t6_done_cycle", 32'(donecyc), 32'd98);

    // Continuous pipeline reads: forced stall every word
    nstall   = 0;
    prev_chk = 0;
    prev_addr = '0;
    i_pipe_read = 1'b1;
    for (int c = 0; c <= 360; c++) begin
      i_dbg_start = (c == 0);
      i_pipe_addr = 5'((c * 5) % 32);
      #1;
      exp_stall = (c >= 9) && (c <= 9 + 11 * 31) && ((c - 9) % 11 == 0);
      chk("t4_stall", 32'(o_pipe_stall), 32'(exp_stall));
      if (o_pipe_stall) nstall++;
      if (prev_chk != 0) chk("t4_pipe_rdata", o_pipe_data, wval(32'(prev_addr)));
      chk("t4_mem_read", 32'(o_mem_read), 32'd1);
      if (exp_stall) chk("t4_dbg_addr_out", 32'(o_mem_address), 32'((c - 9) / 11));
      else chk("t4_pipe_addr_out", 32'(o_mem_address), 32'(i_pipe_addr));
      ev = ((c >= 11) && (c <= 352) && ((c - 11) % 11 == 0)) ? 1 : 0;
      chk("t4_valid", 32'(o_dbg_valid), 32'(ev));
      if (ev != 0) begin
        chk("t4_addr", 32'(o_dbg_addr), 32'((c - 11) / 11));
        chk("t4_word", o_dbg_word, wval((c - 11) / 11));
      end
      chk("t4_done", 32'(o_dbg_done), (c == 354) ? 32'd1 : 32'd0);
      prev_chk  = exp_stall ? 0 : 1;
      prev_addr = i_pipe_addr;
      cyc();
    end
    i_pipe_read = 1'b0;
    i_dbg_start = 1'b0;
    chk("t4_stall_count", 32'(nstall), 32'd32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
